// File: rtl/typedefs.sv
// Shared VeriRISC types and widths for the control/datapath pair.
package typedefs;

    localparam int AW      = 5;
    localparam int DW      = 8;
    localparam int OPC_MSB = DW - 1;
    localparam int OPC_LSB = DW - 3;

    typedef enum logic [2:0] {
        HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR, INST_FETCH, INST_LOAD, IDLE,
        OP_ADDR, OP_FETCH, ALU_OP, STORE
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational VeriRISC ALU: accumulator operand a, memory operand b.
module alu
    import typedefs::*;
#(
    parameter int DW = typedefs::DW
) (
    input  opcode_t         opcode,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [DW-1:0]   y
);

    always_comb begin
        y = a;
        case (opcode)
            ADD:     y = a + b;
            AND:     y = a & b;
            XOR:     y = a ^ b;
            LDA:     y = b;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// VeriRISC datapath: PC, IR, AC and memory addressing. Repeated strobes from
// control are filtered so each instruction has exactly one architectural effect.
module cpu_datapath
    import typedefs::*;
#(
    parameter int AW = typedefs::AW,
    parameter int DW = typedefs::DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_ac,
    input  logic            inc_pc,
    input  logic            load_pc,
    input  logic            load_ir,
    input  logic            halt,
    input  logic [DW-1:0]   mem_rdata,
    output opcode_t         opcode,
    output logic            zero,
    output logic [AW-1:0]   ir_addr,
    output logic [AW-1:0]   pc,
    output logic [DW-1:0]   ac,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic            halted
);

    logic [DW-1:0] ir;
    logic [DW-1:0] alu_out;
    state_t        phase;
    logic          ac_done;
    logic [1:0]    inc_cnt;
    logic          fetch;

    assign opcode    = opcode_t'(ir[DW-1 -: 3]);
    assign ir_addr   = ir[AW-1:0];
    assign zero      = (ac == '0);
    assign fetch     = (phase < OP_ADDR);
    assign mem_addr  = fetch ? pc : ir_addr;
    assign mem_wdata = ac;

    alu #(.DW(DW)) u_alu (
        .opcode (opcode),
        .a      (ac),
        .b      (mem_rdata),
        .y      (alu_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= INST_ADDR;
            pc      <= '0;
            ir      <= '0;
            ac      <= '0;
            halted  <= 1'b0;
            ac_done <= 1'b0;
            inc_cnt <= 2'd0;
        end else begin
            phase <= state_t'(phase + 3'd1);
            if (halt) begin
                halted <= 1'b1;
            end
            if (!halted) begin
                // A simultaneous IR load starts a fresh instruction, so AC is not blocked.
                if (load_ac && (!ac_done || load_ir)) begin
                    ac      <= alu_out;
                    ac_done <= 1'b1;
                end
                if (!halt) begin
                    if (load_pc) begin
                        pc <= ir_addr;
                    end else if (inc_pc && (inc_cnt < 2'd2)) begin
                        pc      <= pc + AW'(1);
                        inc_cnt <= inc_cnt + 2'd1;
                    end
                end
                // Placed last so a new instruction always clears the per-instruction flags.
                if (load_ir) begin
                    ir      <= mem_rdata;
                    ac_done <= 1'b0;
                    inc_cnt <= 2'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: a behavioural control sequencer and memory drive the
// DUT; per-instruction PC/AC/halted and memory writes are scoreboarded.
module tb_cpu_datapath;
    import typedefs::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_ac, inc_pc, load_pc, load_ir, halt;
    logic [DW-1:0]   mem_rdata;
    opcode_t         opcode;
    logic            zero;
    logic [AW-1:0]   ir_addr, pc, mem_addr;
    logic [DW-1:0]   ac, mem_wdata;
    logic            halted;

    cpu_datapath dut (
        .clk       (clk),
        .rst       (rst),
        .load_ac   (load_ac),
        .inc_pc    (inc_pc),
        .load_pc   (load_pc),
        .load_ir   (load_ir),
        .halt      (halt),
        .mem_rdata (mem_rdata),
        .opcode    (opcode),
        .zero      (zero),
        .ir_addr   (ir_addr),
        .pc        (pc),
        .ac        (ac),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] ac;
        logic          halted;
    } exp_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    exp_t          exp_q[$];
    wr_t           wr_q[$];
    logic [DW-1:0] mem [0:31];
    logic [2:0]    ph;
    logic          mem_wr;
    int            tests = 0;
    int            fails = 0;

    function automatic logic [DW-1:0] ins(opcode_t op, logic [AW-1:0] a);
        return {op, a};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    endtask

    task automatic clear_strobes();
        load_ac = 1'b0; inc_pc = 1'b0; load_pc = 1'b0;
        load_ir = 1'b0; halt = 1'b0; mem_wr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_strobes();
        mem_rdata = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ph  = 3'd0;
    endtask

    // One cycle of the control sequence; memory writes are scoreboarded here.
    task automatic run_cycle();
        logic          alu_op;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        wr_t           w;
        @(negedge clk);
        alu_op = opcode inside {ADD, AND, XOR, LDA};
        clear_strobes();
        case (ph)
            3'd2, 3'd3: load_ir = 1'b1;
            3'd4: begin
                inc_pc = 1'b1;
                halt   = (opcode == HLT);
            end
            3'd6: begin
                load_ac = alu_op;
                load_pc = (opcode == JMP);
                inc_pc  = (opcode == SKZ) && zero;
            end
            3'd7: begin
                load_ac = alu_op;
                load_pc = (opcode == JMP);
                inc_pc  = (opcode == JMP) || ((opcode == SKZ) && zero);
                mem_wr  = (opcode == STO);
            end
            default: ;
        endcase
        mem_rdata = mem[mem_addr];
        wa = mem_addr;
        wd = mem_wdata;
        if (mem_wr) begin
            tests++;
            if (wr_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write addr=%0d data=%h (no write expected)", wa, wd);
            end else begin
                w = wr_q.pop_front();
                if (wa !== w.addr || wd !== w.data) begin
                    fails++;
                    $display("FAIL mem_write got addr=%0d data=%h expected addr=%0d data=%h",
                             wa, wd, w.addr, w.data);
                end
            end
        end
        @(posedge clk);
        if (mem_wr) mem[wa] = wd;
        ph = ph + 3'd1;
    endtask

    task automatic run_instr();
        exp_t e;
        for (int i = 0; i < 8; i++) run_cycle();
        #1;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty pc=%0d ac=%h (no expectation queued)", pc, ac);
        end else begin
            e = exp_q.pop_front();
            if (pc !== e.pc) begin
                fails++;
                $display("FAIL instr_pc got %0d expected %0d", pc, e.pc);
            end
            tests++;
            if (ac !== e.ac) begin
                fails++;
                $display("FAIL instr_ac got %h expected %h", ac, e.ac);
            end
            tests++;
            if (halted !== e.halted) begin
                fails++;
                $display("FAIL instr_halted got %b expected %b", halted, e.halted);
            end
        end
    endtask

    task automatic test_reset();
        clear_mem();
        do_reset();
        mem[0] = ins(LDA, 5'd10); mem[10] = 8'h55;
        mem[1] = ins(LDA, 5'd11); mem[11] = 8'h66;
        exp_q.push_back('{pc: 5'd1, ac: 8'h55, halted: 1'b0});
        run_instr();
        for (int i = 0; i < 5; i++) run_cycle();
        do_reset();
        tests++; if (pc !== 5'd0)       begin fails++; $display("FAIL reset_pc got %0d expected 0", pc); end
        tests++; if (ac !== 8'h00)      begin fails++; $display("FAIL reset_ac got %h expected 00", ac); end
        tests++; if (zero !== 1'b1)     begin fails++; $display("FAIL reset_zero got %b expected 1", zero); end
        tests++; if (halted !== 1'b0)   begin fails++; $display("FAIL reset_halted got %b expected 0", halted); end
        tests++; if (mem_addr !== 5'd0) begin fails++; $display("FAIL reset_mem_addr got %0d expected 0", mem_addr); end
        tests++; if (ir_addr !== 5'd0)  begin fails++; $display("FAIL reset_ir_addr got %0d expected 0", ir_addr); end
        tests++; if (opcode !== HLT)    begin fails++; $display("FAIL reset_opcode got %0d expected 0", opcode); end
        exp_q.push_back('{pc: 5'd1, ac: 8'h55, halted: 1'b0});
        run_instr();
    endtask

    task automatic test_alu_ops();
        clear_mem();
        do_reset();
        mem[0] = ins(LDA, 5'd10); mem[10] = 8'h05;
        mem[1] = ins(ADD, 5'd11); mem[11] = 8'hFE;
        mem[2] = ins(AND, 5'd12); mem[12] = 8'h06;
        mem[3] = ins(XOR, 5'd13); mem[13] = 8'hFF;
        exp_q.push_back('{pc: 5'd1, ac: 8'h05, halted: 1'b0});
        run_instr();
        exp_q.push_back('{pc: 5'd2, ac: 8'h03, halted: 1'b0});
        run_instr();
        exp_q.push_back('{pc: 5'd3, ac: 8'h02, halted: 1'b0});
        run_instr();
        exp_q.push_back('{pc: 5'd4, ac: 8'hFD, halted: 1'b0});
        run_instr();
        tests++; if (zero !== 1'b0) begin fails++; $display("FAIL alu_zero got %b expected 0", zero); end
    endtask

    task automatic test_skz();
        clear_mem();
        do_reset();
        for (int i = 0; i < 3; i++) mem[i] = ins(LDA, 5'd14);
        mem[14] = 8'h00;
        mem[3]  = ins(SKZ, 5'd0);
        mem[4]  = ins(HLT, 5'd0);
        mem[5]  = ins(LDA, 5'd15); mem[15] = 8'h07;
        mem[6]  = ins(SKZ, 5'd0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{pc: 5'(i + 1), ac: 8'h00, halted: 1'b0});
            run_instr();
        end
        tests++; if (zero !== 1'b1) begin fails++; $display("FAIL skz_zero got %b expected 1", zero); end
        exp_q.push_back('{pc: 5'd5, ac: 8'h00, halted: 1'b0});
        run_instr();
        exp_q.push_back('{pc: 5'd6, ac: 8'h07, halted: 1'b0});
        run_instr();
        exp_q.push_back('{pc: 5'd7, ac: 8'h07, halted: 1'b0});
        run_instr();
    endtask

    task automatic test_jmp();
        clear_mem();
        do_reset();
        for (int i = 0; i < 7; i++) mem[i] = ins(LDA, 5'd14);
        mem[14] = 8'h3C;
        mem[7]  = ins(JMP, 5'h1C);
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back('{pc: 5'(i + 1), ac: 8'h3C, halted: 1'b0});
            run_instr();
        end
        exp_q.push_back('{pc: 5'h1C, ac: 8'h3C, halted: 1'b0});
        run_instr();
    endtask

    task automatic test_sto();
        clear_mem();
        do_reset();
        mem[0] = ins(LDA, 5'd16); mem[16] = 8'hA5;
        mem[1] = ins(STO, 5'd20);
        exp_q.push_back('{pc: 5'd1, ac: 8'hA5, halted: 1'b0});
        run_instr();
        wr_q.push_back('{addr: 5'd20, data: 8'hA5});
        exp_q.push_back('{pc: 5'd2, ac: 8'hA5, halted: 1'b0});
        run_instr();
        tests++;
        if (wr_q.size() != 0) begin
            fails++;
            $display("FAIL sto_missing pending=%0d expected 0", wr_q.size());
            wr_q.delete();
        end
        tests++; if (mem[20] !== 8'hA5) begin fails++; $display("FAIL sto_mem got %h expected a5", mem[20]); end
    endtask

    task automatic test_halt_wrap();
        clear_mem();
        do_reset();
        mem[0]  = ins(JMP, 5'd31);
        mem[31] = ins(HLT, 5'd0);
        exp_q.push_back('{pc: 5'd31, ac: 8'h00, halted: 1'b0});
        run_instr();
        exp_q.push_back('{pc: 5'd31, ac: 8'h00, halted: 1'b1});
        run_instr();
        // A loadable instruction now sits at pc 31; a frozen IR must ignore it.
        mem[31] = ins(LDA, 5'd16); mem[16] = 8'h77;
        for (int i = 0; i < 100; i++) run_cycle();
        #1;
        tests++; if (pc !== 5'd31)    begin fails++; $display("FAIL halt_pc got %0d expected 31", pc); end
        tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_sticky got %b expected 1", halted); end
        tests++; if (ac !== 8'h00)    begin fails++; $display("FAIL halt_ac got %h expected 00", ac); end
        tests++; if (opcode !== HLT)  begin fails++; $display("FAIL halt_opcode got %0d expected 0", opcode); end
        do_reset();
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_clear got %b expected 0", halted); end
        exp_q.push_back('{pc: 5'd31, ac: 8'h00, halted: 1'b0});
        run_instr();
        exp_q.push_back('{pc: 5'd0, ac: 8'h77, halted: 1'b0});
        run_instr();
    endtask

    initial begin
        rst = 1'b1;
        clear_strobes();
        mem_rdata = '0;
        ph = 3'd0;
        test_reset();
        test_alu_ops();
        test_skz();
        test_jmp();
        test_sto();
        test_halt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached tests=%0d", tests);
        $fatal(1, "time limit");
    end

endmodule
